// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   D_WIDTH_DEF : default number of data bits per frame
//   FRAME_BITS  : frame length (start + data + stop) for the default width
//   rx_state_t  : receiver FSM state encoding
//   frame_bits(): frame length for an arbitrary data width
package uart_pkg;

    localparam int unsigned D_WIDTH_DEF = 6;
    localparam int unsigned FRAME_BITS  = D_WIDTH_DEF + 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int unsigned frame_bits(input int unsigned d_width);
        return d_width + 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync -- two-flop synchronizer for the asynchronous serial line.
//   clk : clock
//   rst : synchronous active-high reset, both flops forced to 1 (idle line)
//   d   : asynchronous input
//   q   : synchronized output
module uart_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver: start bit 0, D_WIDTH data bits LSB first, one
// stop bit 1, CLKS_PER_BIT clocks per bit, each bit sampled MID clocks into it.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial input, idle high
//   rx_ready  : consumer accepts rx_data when high together with rx_valid
//   rx_data   : last received data word
//   rx_valid  : rx_data holds an unconsumed word
//   rx_busy   : frame reception in progress
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good frame dropped because rx_valid was held
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned D_WIDTH      = D_WIDTH_DEF,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);

    localparam int unsigned MID      = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned STOP_IDX = frame_bits(D_WIDTH) - 1;
    localparam int unsigned CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW       = $clog2(STOP_IDX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(MID);
    localparam logic [BW-1:0] BIT_LAST  = BW'(D_WIDTH);

    rx_state_t          state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt, phase_now;
    logic [BW-1:0]      bitcnt, bitcnt_nxt, bit_now;
    logic [D_WIDTH-1:0] shift, shift_nxt, shifted;
    logic [D_WIDTH-1:0] rx_data_nxt;
    logic               rx_valid_nxt, frame_err_nxt, overrun_nxt;
    logic               sample_now;
    logic               rx_s;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign rx_busy = (state != IDLE);

    // cnt/bitcnt hold the position (phase, bit) of the previous edge relative
    // to the start-detect edge E; the current edge is one phase further.
    // With MID == 0 the start sample coincides with E itself, so START then
    // sees data bit 1 as its first sample and handles it like DATA.
    always_comb begin
        if (cnt == CNT_LAST) begin
            phase_now = '0;
            bit_now   = bitcnt + 1'b1;
        end else begin
            phase_now = cnt + 1'b1;
            bit_now   = bitcnt;
        end
        sample_now = (phase_now == CNT_MID);
    end

    // MSB-in shift: the first data bit ends at position 0
    always_comb begin
        shifted = '0;
        for (int unsigned i = 0; i < D_WIDTH - 1; i++) begin
            shifted[i] = shift[i+1];
        end
        shifted[D_WIDTH-1] = rx_s;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = phase_now;
        bitcnt_nxt    = bit_now;
        shift_nxt     = shift;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = rx_valid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;

        if (rx_valid && rx_ready) begin
            rx_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_nxt    = '0;
                bitcnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START, DATA: begin
                if (sample_now) begin
                    if (bit_now == '0) begin
                        if (rx_s) begin
                            state_nxt  = IDLE;
                            cnt_nxt    = '0;
                            bitcnt_nxt = '0;
                        end else begin
                            state_nxt = DATA;
                        end
                    end else begin
                        shift_nxt = shifted;
                        state_nxt = (bit_now == BIT_LAST) ? STOP : DATA;
                    end
                end
            end
            STOP: begin
                if (sample_now) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    bitcnt_nxt = '0;
                    if (!rx_s) begin
                        frame_err_nxt = 1'b1;
                    end else if (!rx_valid || rx_ready) begin
                        rx_data_nxt  = shift;
                        rx_valid_nxt = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                bitcnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bitcnt    <= bitcnt_nxt;
            shift     <= shift_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx: dut0 runs at 1 clock per bit,
// dut1 at 4 clocks per bit. Expected output events (word load, frame error,
// overrun) with their cycle are queued by the stimulus; monitors compare.
module tb_uart_rx;

    localparam int unsigned DW = 6;
    localparam int K_LOAD = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int             kind;
        logic [DW-1:0]  data;
        int unsigned    cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_w   [2];
    logic          rx_w    [2];
    logic          rdy_w   [2];
    logic [DW-1:0] data_w  [2];
    logic          valid_w [2];
    logic          busy_w  [2];
    logic          ferr_w  [2];
    logic          ovr_w   [2];

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    ev_t         q0[$];
    ev_t         q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.D_WIDTH(DW), .CLKS_PER_BIT(1)) dut0 (
        .clk(clk), .rst(rst_w[0]), .rx(rx_w[0]), .rx_ready(rdy_w[0]),
        .rx_data(data_w[0]), .rx_valid(valid_w[0]), .rx_busy(busy_w[0]),
        .frame_err(ferr_w[0]), .overrun(ovr_w[0])
    );

    uart_rx #(.D_WIDTH(DW), .CLKS_PER_BIT(4)) dut1 (
        .clk(clk), .rst(rst_w[1]), .rx(rx_w[1]), .rx_ready(rdy_w[1]),
        .rx_data(data_w[1]), .rx_valid(valid_w[1]), .rx_busy(busy_w[1]),
        .frame_err(ferr_w[1]), .overrun(ovr_w[1])
    );

    function automatic int unsigned cpb_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // start driven low just after edge c0: E = c0+3 (two sync flops),
    // stop sample at E + (DW+1)*CPB + MID, visible after that edge
    function automatic int unsigned stop_cyc(input int u, input int unsigned c0);
        return c0 + 3 + (DW + 1) * cpb_of(u) + (cpb_of(u) - 1) / 2;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int u, input int kind, input logic [DW-1:0] data,
                           input int unsigned c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic sb_check(input int u, input int kind, input logic [DW-1:0] data);
        ev_t e;
        n_vec++;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_event dut%0d: got kind %0d data 0x%h cycle %0d, required no event",
                     u, kind, data, cyc);
            return;
        end
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.kind != kind || e.data != data || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event dut%0d: got kind %0d data 0x%h cycle %0d, required kind %0d data 0x%h cycle %0d",
                     u, kind, data, cyc, e.kind, e.data, e.cyc);
        end
    endtask

    task automatic monitor(input int u);
        logic pv = 1'b0;
        logic pr = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_w[u] === 1'b1 && (!pv || pr)) sb_check(u, K_LOAD, data_w[u]);
            if (ferr_w[u] === 1'b1)                sb_check(u, K_FERR, data_w[u]);
            if (ovr_w[u] === 1'b1)                 sb_check(u, K_OVR,  data_w[u]);
            pv = (valid_w[u] === 1'b1);
            pr = rdy_w[u];
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic send_bits(input int u, input logic [DW-1:0] d, input logic stop);
        logic [DW+1:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < DW + 2; i++) begin
            rx_w[u] = f[i];
            repeat (cpb_of(u)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        for (int u = 0; u < 2; u++) begin
            rst_w[u] = 1'b1;
            rx_w[u]  = 1'b1;
            rdy_w[u] = 1'b1;
        end
        idle(3);
        chk("reset_state_dut0", {data_w[0], valid_w[0], busy_w[0], ferr_w[0], ovr_w[0]}, '0);
        chk("reset_state_dut1", {data_w[1], valid_w[1], busy_w[1], ferr_w[1], ovr_w[1]}, '0);
        rst_w[0] = 1'b0;
        rst_w[1] = 1'b0;
        idle(3);

        // basic frame 0x2D, consumer ready
        c0 = cyc;
        push_ev(0, K_LOAD, 6'h2D, stop_cyc(0, c0));
        send_bits(0, 6'h2D, 1'b1);
        idle(4);

        // one-cycle glitch on the 4-clock receiver
        c0 = cyc;
        rx_w[1] = 1'b0;
        idle(1);
        rx_w[1] = 1'b1;
        idle(2);
        chk("glitch_busy_at_E", {31'd0, busy_w[1]}, 32'd1);
        idle(1);
        chk("glitch_back_to_idle", {31'd0, busy_w[1]}, 32'd0);
        idle(4);

        // real frames on the 4-clock receiver
        c0 = cyc;
        push_ev(1, K_LOAD, 6'h2D, stop_cyc(1, c0));
        send_bits(1, 6'h2D, 1'b1);
        idle(2);
        c0 = cyc;
        push_ev(1, K_LOAD, 6'h1C, stop_cyc(1, c0));
        send_bits(1, 6'h1C, 1'b1);
        idle(8);

        // frame 0x15 with bad stop bit: rx_data keeps the previous word
        c0 = cyc;
        push_ev(0, K_FERR, 6'h2D, stop_cyc(0, c0));
        send_bits(0, 6'h15, 1'b0);
        rx_w[0] = 1'b1;
        idle(4);
        chk("ferr_no_valid", {31'd0, valid_w[0]}, 32'd0);

        // overrun: consumer stalled, two back-to-back frames
        rdy_w[0] = 1'b0;
        c0 = cyc;
        push_ev(0, K_LOAD, 6'h0A, stop_cyc(0, c0));
        push_ev(0, K_OVR,  6'h0A, stop_cyc(0, c0 + 8));
        send_bits(0, 6'h0A, 1'b1);
        send_bits(0, 6'h33, 1'b1);
        idle(4);
        chk("overrun_data_held", {26'd0, data_w[0]}, 32'h0A);
        chk("overrun_valid_held", {31'd0, valid_w[0]}, 32'd1);
        rdy_w[0] = 1'b1;
        idle(1);
        chk("overrun_consumed", {31'd0, valid_w[0]}, 32'd0);
        idle(2);

        // consume on the same edge as the second stop sample
        rdy_w[0] = 1'b0;
        c0 = cyc;
        push_ev(0, K_LOAD, 6'h0A, stop_cyc(0, c0));
        push_ev(0, K_LOAD, 6'h33, stop_cyc(0, c0 + 8));
        fork
            begin
                send_bits(0, 6'h0A, 1'b1);
                send_bits(0, 6'h33, 1'b1);
            end
            begin
                idle(17);
                rdy_w[0] = 1'b1;
                idle(1);
                rdy_w[0] = 1'b0;
            end
        join
        idle(3);
        chk("same_edge_data", {26'd0, data_w[0]}, 32'h33);
        chk("same_edge_valid", {31'd0, valid_w[0]}, 32'd1);
        rdy_w[0] = 1'b1;
        idle(1);
        chk("same_edge_consumed", {31'd0, valid_w[0]}, 32'd0);
        idle(2);

        // reset during data bit 3, then a clean frame
        c0 = cyc;
        fork
            send_bits(0, 6'h38, 1'b1);
            begin
                idle(5);
                rst_w[0] = 1'b1;
                idle(2);
                rst_w[0] = 1'b0;
            end
        join
        idle(4);
        chk("midframe_reset_state", {24'd0, data_w[0], valid_w[0], busy_w[0]}, '0);
        c0 = cyc;
        push_ev(0, K_LOAD, 6'h3F, stop_cyc(0, c0));
        send_bits(0, 6'h3F, 1'b1);
        idle(6);

        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
